// File: rtl/ctrl_unit_pipe.sv
// Registered ID->EX control decoder for the 3-stage RV32I(+M) core, with MUL/DIV stall FSM.
// Optional feature macro: RV32M_EN (M-extension decode + multi-cycle stall FSM).
module ctrl_unit_pipe #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_F,
  input  logic            valid_F,
  input  logic            flush,
  output logic [3:0]      aluop_EX,
  output logic [1:0]      alusrc_EX,
  output logic [1:0]      regsel_EX,
  output logic            regwrite_EX,
  output logic            GPIO_we,
  output logic            div_signed_EX,
  output logic [XLEN-1:0] imm_EX,
  output logic [4:0]      rd_EX,
  output logic            illegal_EX,
  output logic            stall_F
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam bit            MUL_STALL = (MUL_CYCLES > 1);
  localparam bit            DIV_STALL = (DIV_CYCLES > 1);
  localparam logic [CW-1:0] MUL_LD    = MUL_STALL ? CW'(MUL_CYCLES - 1) : '0;
  localparam logic [CW-1:0] DIV_LD    = DIV_STALL ? CW'(DIV_CYCLES - 1) : '0;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [11:0] CSR_GPIO_OUT = 12'hF02;
  localparam logic [11:0] CSR_GPIO_IN  = 12'hF00;

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_XOR  = 4'h2;
  localparam logic [3:0] ALU_ADD  = 4'h3;
  localparam logic [3:0] ALU_SUB  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
`ifdef RV32M_EN
  localparam logic [3:0] ALU_MUL  = 4'hA;
  localparam logic [3:0] ALU_DIV  = 4'hE;
  localparam logic [3:0] ALU_REM  = 4'hF;
`endif

  localparam logic [1:0] SRC_RS2 = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_PC  = 2'b10;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_GPIO = 2'b01;
  localparam logic [1:0] WB_IMM  = 2'b10;

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [11:0]     w_csr;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;

  assign w_opc   = instr_F[6:0];
  assign w_f3    = instr_F[14:12];
  assign w_f7    = instr_F[31:25];
  assign w_rd    = instr_F[11:7];
  assign w_csr   = instr_F[31:20];
  assign w_imm_i = XLEN'($signed(instr_F[31:20]));
  assign w_imm_u = XLEN'($signed({instr_F[31:12], 12'b0}));

  logic            w_ok;
  logic            w_wr;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_gpio_we;
  logic            w_div_signed;
  logic [3:0]      w_base_op;
  logic [3:0]      w_aluop;
  logic [1:0]      w_alusrc;
  logic [1:0]      w_regsel;
  logic [XLEN-1:0] w_imm;

  // funct3 -> op shared by R-type (funct7=0) and I-ALU encodings
  always_comb begin
    case (w_f3)
      3'b000:  w_base_op = ALU_ADD;
      3'b001:  w_base_op = ALU_SLL;
      3'b010:  w_base_op = ALU_SLT;
      3'b011:  w_base_op = ALU_SLTU;
      3'b100:  w_base_op = ALU_XOR;
      3'b101:  w_base_op = ALU_SRL;
      3'b110:  w_base_op = ALU_OR;
      default: w_base_op = ALU_AND;
    endcase
  end

  always_comb begin
    w_ok         = 1'b0;
    w_wr         = 1'b0;
    w_is_mul     = 1'b0;
    w_is_div     = 1'b0;
    w_gpio_we    = 1'b0;
    w_div_signed = 1'b0;
    w_aluop      = ALU_AND;
    w_alusrc     = SRC_RS2;
    w_regsel     = WB_ALU;
    w_imm        = '0;
    case (w_opc)
      OP_R: begin
        w_wr = 1'b1;
        case (w_f7)
          7'h00: begin
            w_ok    = 1'b1;
            w_aluop = w_base_op;
          end
          7'h20: begin
            w_ok    = (w_f3 == 3'b000) || (w_f3 == 3'b101);
            w_aluop = (w_f3 == 3'b000) ? ALU_SUB : ALU_SRA;
          end
`ifdef RV32M_EN
          7'h01: begin
            w_ok         = 1'b1;
            w_is_div     = w_f3[2];
            w_is_mul     = !w_f3[2];
            w_div_signed = w_f3[2] && !w_f3[0];
            if (!w_f3[2]) w_aluop = ALU_MUL + {2'b00, w_f3[1:0]};
            else          w_aluop = w_f3[1] ? ALU_REM : ALU_DIV;
          end
`endif
          default: w_ok = 1'b0;
        endcase
      end
      OP_I: begin
        w_wr     = 1'b1;
        w_alusrc = SRC_IMM;
        w_imm    = w_imm_i;
        w_aluop  = w_base_op;
        // shift-immediates reserve imm[11:5]; only SRAI may set bit 10
        case (w_f3)
          3'b001: w_ok = (w_f7 == 7'h00);
          3'b101: begin
            w_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20);
            if (w_f7 == 7'h20) w_aluop = ALU_SRA;
          end
          default: w_ok = 1'b1;
        endcase
      end
      OP_LUI: begin
        w_ok     = 1'b1;
        w_wr     = 1'b1;
        w_regsel = WB_IMM;
        w_imm    = w_imm_u;
      end
      OP_AUIPC: begin
        w_ok     = 1'b1;
        w_wr     = 1'b1;
        w_alusrc = SRC_PC;
        w_aluop  = ALU_ADD;
        w_imm    = w_imm_u;
      end
      OP_SYS: begin
        if (w_f3 == 3'b001 && w_csr == CSR_GPIO_OUT) begin
          w_ok      = 1'b1;
          w_gpio_we = 1'b1;
        end else if (w_f3 == 3'b001 && w_csr == CSR_GPIO_IN) begin
          w_ok     = 1'b1;
          w_wr     = 1'b1;
          w_regsel = WB_GPIO;
        end
      end
      default: w_ok = 1'b0;
    endcase
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // counter holds remaining WAIT cycles; an N-cycle op leaves WAIT when it reads 1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (valid_F && !flush && w_ok) begin
          if (w_is_div && DIV_STALL) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = DIV_LD;
          end else if (w_is_mul && MUL_STALL) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = MUL_LD;
          end
        end
      end
      S_WAIT: begin
        if (flush || r_cnt == CW'(1)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
    endcase
  end

  assign stall_F = (r_state == S_WAIT);

  logic [3:0]      r_aluop;
  logic [1:0]      r_alusrc;
  logic [1:0]      r_regsel;
  logic            r_regwrite;
  logic            r_gpio_we;
  logic            r_div_signed;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd;
  logic            r_illegal;

  // EX regs: flush always kills; in WAIT they otherwise hold the multi-cycle op
  always_ff @(posedge clk) begin
    if (!rst_n || flush || (r_state == S_RUN && !valid_F)) begin
      r_aluop      <= '0;
      r_alusrc     <= '0;
      r_regsel     <= '0;
      r_regwrite   <= 1'b0;
      r_gpio_we    <= 1'b0;
      r_div_signed <= 1'b0;
      r_imm        <= '0;
      r_rd         <= '0;
      r_illegal    <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_aluop      <= w_ok ? w_aluop : '0;
      r_alusrc     <= w_ok ? w_alusrc : '0;
      r_regsel     <= w_ok ? w_regsel : '0;
      r_regwrite   <= w_ok && w_wr && (w_rd != 5'd0);
      r_gpio_we    <= w_ok && w_gpio_we;
      r_div_signed <= w_ok && w_div_signed;
      r_imm        <= w_ok ? w_imm : '0;
      r_rd         <= w_ok ? w_rd : '0;
      r_illegal    <= !w_ok;
    end
  end

  assign aluop_EX      = r_aluop;
  assign alusrc_EX     = r_alusrc;
  assign regsel_EX     = r_regsel;
  assign regwrite_EX   = r_regwrite;
  assign GPIO_we       = r_gpio_we;
  assign div_signed_EX = r_div_signed;
  assign imm_EX        = r_imm;
  assign rd_EX         = r_rd;
  assign illegal_EX    = r_illegal;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Bench for ctrl_unit_pipe: directed vector table, stall/flush/reset sequences, random vs. reference model.
module tb_ctrl_unit_pipe;
  localparam int MUL_C = 2;
  localparam int DIV_C = 4;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  localparam logic [31:0] I_ADD = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_DIV = 32'h027342B3;  // div x5,x6,x7
  localparam logic [31:0] I_MUL = 32'h022081B3;  // mul x3,x1,x2

  // funct3 -> aluop for R (funct7=0) and I-ALU forms
  localparam logic [3:0] BASE_OP [8] = '{4'h3, 4'h5, 4'h8, 4'h9, 4'h2, 4'h6, 4'h1, 4'h0};

  typedef struct packed {
    logic [3:0]  aluop;
    logic [1:0]  alusrc;
    logic [1:0]  regsel;
    logic        regwrite;
    logic        gpio;
    logic        dsig;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        ill;
    logic        stall;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic        v;
    logic        f;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] instr_F;
  logic        valid_F;
  logic        flush;
  logic [3:0]  aluop_EX;
  logic [1:0]  alusrc_EX;
  logic [1:0]  regsel_EX;
  logic        regwrite_EX;
  logic        GPIO_we;
  logic        div_signed_EX;
  logic [31:0] imm_EX;
  logic [4:0]  rd_EX;
  logic        illegal_EX;
  logic        stall_F;

  ctrl_unit_pipe #(.XLEN(32), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .rst_n(rst_n), .instr_F(instr_F), .valid_F(valid_F), .flush(flush),
    .aluop_EX(aluop_EX), .alusrc_EX(alusrc_EX), .regsel_EX(regsel_EX),
    .regwrite_EX(regwrite_EX), .GPIO_we(GPIO_we), .div_signed_EX(div_signed_EX),
    .imm_EX(imm_EX), .rd_EX(rd_EX), .illegal_EX(illegal_EX), .stall_F(stall_F)
  );

  exp_t act;
  assign act = {aluop_EX, alusrc_EX, regsel_EX, regwrite_EX, GPIO_we, div_signed_EX,
                imm_EX, rd_EX, illegal_EX, stall_F};

  int   errs = 0;
  int   checks = 0;
  exp_t m_ex;
  int   m_busy;

  function automatic exp_t mk(logic [3:0] op, logic [1:0] src, logic [1:0] sel, logic rw,
                              logic g, logic ds, logic [31:0] imm, logic [4:0] rd, logic ill);
    exp_t e;
    e = '{aluop: op, alusrc: src, regsel: sel, regwrite: rw, gpio: g, dsig: ds,
          imm: imm, rd: rd, ill: ill, stall: 1'b0};
    return e;
  endfunction

  // Decode straight from the ISA rules; occ = EX occupancy in cycles
  function automatic exp_t ref_decode(input logic [31:0] ins, output int occ);
    exp_t e;
    logic ok, wr;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0; ok = 1'b0; wr = 1'b0; occ = 1;
    f3 = ins[14:12]; f7 = ins[31:25];
    case (ins[6:0])
      7'h33: begin
        wr = 1'b1;
        if (f7 == 7'h00) begin ok = 1'b1; e.aluop = BASE_OP[f3]; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; e.aluop = 4'h4; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; e.aluop = 4'h7; end
        else if (f7 == 7'h01 && M_EN) begin
          ok = 1'b1;
          if (f3 < 3'd4) begin e.aluop = 4'(10 + f3); occ = MUL_C; end
          else begin
            e.aluop = (f3 >= 3'd6) ? 4'hF : 4'hE;
            e.dsig  = (f3 == 3'd4 || f3 == 3'd6);
            occ     = DIV_C;
          end
        end
      end
      7'h13: begin
        wr = 1'b1; e.alusrc = 2'b01; e.imm = {{20{ins[31]}}, ins[31:20]};
        if (f3 == 3'd1) begin ok = (f7 == 7'h00); e.aluop = 4'h5; end
        else if (f3 == 3'd5) begin
          ok = (f7 == 7'h00 || f7 == 7'h20);
          e.aluop = (f7 == 7'h20) ? 4'h7 : 4'h6;
        end else begin ok = 1'b1; e.aluop = BASE_OP[f3]; end
      end
      7'h37: begin ok = 1'b1; wr = 1'b1; e.regsel = 2'b10; e.imm = {ins[31:12], 12'h000}; end
      7'h17: begin
        ok = 1'b1; wr = 1'b1; e.alusrc = 2'b10; e.aluop = 4'h3; e.imm = {ins[31:12], 12'h000};
      end
      7'h73: begin
        if (f3 == 3'd1 && ins[31:20] == 12'hF02) begin ok = 1'b1; e.gpio = 1'b1; end
        else if (f3 == 3'd1 && ins[31:20] == 12'hF00) begin ok = 1'b1; wr = 1'b1; e.regsel = 2'b01; end
      end
      default: ok = 1'b0;
    endcase
    if (ok) begin
      e.rd = ins[11:7];
      e.regwrite = wr && (ins[11:7] != 5'd0);
    end else begin
      e = '0; e.ill = 1'b1; occ = 1;
    end
    return e;
  endfunction

  function automatic exp_t mexp();
    exp_t e;
    e = m_ex;
    e.stall = (m_busy > 0);
    return e;
  endfunction

  // Drive one cycle, advance the reference model on the edge, sample 1ns later
  task automatic step(input logic [31:0] ins, input logic v, input logic f, input logic r);
    int occ;
    instr_F = ins; valid_F = v; flush = f; rst_n = r;
    @(posedge clk);
    if (!r) begin m_ex = '0; m_busy = 0; end
    else if (m_busy > 0) begin
      if (f) begin m_ex = '0; m_busy = 0; end
      else m_busy--;
    end else if (f || !v) m_ex = '0;
    else begin m_ex = ref_decode(ins, occ); m_busy = occ - 1; end
    #1;
  endtask

  task automatic chk(input string nm, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  function automatic logic [6:0] pick_f7();
    logic [6:0] f7;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return f7;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r, ins;
    logic [11:0] csr;
    logic [2:0]  f3;
    logic [4:0]  rd;
    r  = $urandom;
    rd = ($urandom_range(0, 4) == 0) ? 5'd0 : r[11:7];
    case ($urandom_range(0, 7))
      0: ins = {pick_f7(), r[24:12], rd, 7'h33};
      1: begin
        ins = {r[31:12], rd, 7'h13};
        if (r[13:12] == 2'b01) ins[31:25] = pick_f7();
      end
      2: ins = {r[31:12], rd, 7'h37};
      3: ins = {r[31:12], rd, 7'h17};
      4: begin
        case ($urandom_range(0, 2))
          0: csr = 12'hF00;
          1: csr = 12'hF02;
          default: csr = r[31:20];
        endcase
        f3  = ($urandom_range(0, 3) == 0) ? r[14:12] : 3'b001;
        ins = {csr, r[19:15], f3, rd, 7'h73};
      end
      5: ins = r;
      6: ins = {7'h01, r[24:12], rd, 7'h33};
      default: ins = {7'h00, r[24:12], rd, 7'h33};
    endcase
    return ins;
  endfunction

  initial begin
    vec_t tbl [22];
    exp_t ILL, e_add, e_div, e_mul;
    int nst, nhold;

    ILL   = mk(4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1);
    e_add = mk(4'h3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 5'd3, 1'b0);
    e_div = mk(4'hE, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0, 5'd5, 1'b0);
    e_mul = mk(4'hA, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 5'd3, 1'b0);

    tbl[0]  = '{I_ADD,        1'b1, 1'b0, e_add};
    tbl[1]  = '{32'h123450B7, 1'b1, 1'b0, mk(4'h0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 32'h12345000, 5'd1, 1'b0)};
    tbl[2]  = '{32'h00500013, 1'b1, 1'b0, mk(4'h3, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 32'h5, 5'd0, 1'b0)};
    tbl[3]  = '{32'hF0229073, 1'b1, 1'b0, mk(4'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0)};
    tbl[4]  = '{32'hF0001273, 1'b1, 1'b0, mk(4'h0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0, 5'd4, 1'b0)};
    tbl[5]  = '{32'h0000007F, 1'b1, 1'b0, ILL};
    tbl[6]  = '{32'h02315093, 1'b1, 1'b0, ILL};
    tbl[7]  = '{32'h40315093, 1'b1, 1'b0, mk(4'h7, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 32'h403, 5'd1, 1'b0)};
    tbl[8]  = '{32'h407302B3, 1'b1, 1'b0, mk(4'h4, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 5'd5, 1'b0)};
    tbl[9]  = '{32'hFFFFF117, 1'b1, 1'b0, mk(4'h3, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 32'hFFFFF000, 5'd2, 1'b0)};
    tbl[10] = '{32'hFFF00093, 1'b1, 1'b0, mk(4'h3, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 5'd1, 1'b0)};
    tbl[11] = '{I_ADD,        1'b0, 1'b0, exp_t'('0)};
    tbl[12] = '{I_ADD,        1'b1, 1'b1, exp_t'('0)};
    tbl[13] = '{32'h003130B3, 1'b1, 1'b0, mk(4'h9, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 5'd1, 1'b0)};
    tbl[14] = '{32'h40311093, 1'b1, 1'b0, ILL};
    tbl[15] = '{32'h12301073, 1'b1, 1'b0, ILL};
    tbl[16] = '{32'h40001033, 1'b1, 1'b0, ILL};
    tbl[17] = '{32'h12345037, 1'b1, 1'b0, mk(4'h0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 32'h12345000, 5'd0, 1'b0)};
    tbl[18] = '{32'hF0001073, 1'b1, 1'b0, mk(4'h0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0)};
    tbl[19] = '{32'h00311093, 1'b1, 1'b0, mk(4'h5, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 32'h3, 5'd1, 1'b0)};
    tbl[20] = '{32'h00315093, 1'b1, 1'b0, mk(4'h6, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 32'h3, 5'd1, 1'b0)};
    tbl[21] = '{32'hF022A073, 1'b1, 1'b0, ILL};

    m_ex = '0; m_busy = 0;
    step(I_ADD, 1'b1, 1'b0, 1'b0);
    step(I_ADD, 1'b1, 1'b1, 1'b0);
    chk("reset", act, '0);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].ins, tbl[i].v, tbl[i].f, 1'b1);
      chk($sformatf("vec%0d", i), act, tbl[i].e);
    end

`ifdef RV32M_EN
    // DIV occupies EX for DIV_C cycles, stalling fetch for DIV_C-1
    nst = 0; nhold = 0;
    step(I_DIV, 1'b1, 1'b0, 1'b1);
    chk("div_first", act, mexp());
    for (int k = 0; k < 6; k++) begin
      if (act.stall) nst++;
      if (act.aluop == 4'hE) nhold++;
      chk($sformatf("div_seq%0d", k), act, mexp());
      step(I_ADD, 1'b1, 1'b0, 1'b1);
    end
    chk_int("div_stall_cycles", nst, DIV_C - 1);
    chk_int("div_hold_cycles", nhold, DIV_C);

    step(I_DIV, 1'b1, 1'b0, 1'b1);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    step(I_ADD, 1'b1, 1'b1, 1'b1);
    chk("flush_wait", act, '0);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    chk("after_flush", act, e_add);

    step(I_DIV, 1'b1, 1'b0, 1'b1);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    step(I_ADD, 1'b1, 1'b0, 1'b0);
    chk("reset_mid_stall", act, '0);
    step(32'h0, 1'b0, 1'b0, 1'b1);

    step(I_DIV, 1'b1, 1'b0, 1'b1);
    step(I_DIV, 1'b1, 1'b0, 1'b1);
    step(I_DIV, 1'b1, 1'b0, 1'b1);
    step(I_DIV, 1'b1, 1'b0, 1'b1);
    chk("b2b_last_hold", act, e_div);
    step(I_DIV, 1'b1, 1'b0, 1'b1);
    e_div.stall = 1'b1;
    chk("b2b_second", act, e_div);
    step(32'h0, 1'b0, 1'b0, 1'b0);

    step(I_MUL, 1'b1, 1'b0, 1'b1);
    e_mul.stall = 1'b1;
    chk("mul_first", act, e_mul);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    e_mul.stall = 1'b0;
    chk("mul_hold", act, e_mul);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    chk("after_mul", act, e_add);
`else
    step(I_DIV, 1'b1, 1'b0, 1'b1);
    chk("div_no_m", act, ILL);
    step(I_MUL, 1'b1, 1'b0, 1'b1);
    chk("mul_no_m", act, ILL);
    step(I_ADD, 1'b1, 1'b0, 1'b1);
    chk("add_after_m", act, e_add);
    step(I_ADD, 1'b1, 1'b0, 1'b0);
    chk("reset_mid_run", act, '0);
`endif

    for (int k = 0; k < 3000; k++) begin
      step(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 99) != 0));
      chk($sformatf("rand%0d", k), act, mexp());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
